// File: rtl/alu_a_sel_if.sv
// Execute-stage A-operand selector bus.
// master: drives opcode, operands and pipeline control; observes the operand.
// slave : the selector; returns the combinational and registered operand.
//   E_op      opcode of the instruction in Execute
//   E_valC    extended immediate
//   E_valA    forwarded register operand A
//   in_valid  Execute-stage instruction is valid
//   stall     hold registered outputs
//   bubble    load a NOP into registered outputs
//   e_aluA    combinational ALU A operand
//   aluA_q    registered ALU A operand
//   valid_q   registered valid
//   illegal_q registered illegal-opcode flag
interface alu_a_sel_if #(
  parameter int unsigned W   = 32,
  parameter int unsigned OPW = 6
);
  logic [OPW-1:0] E_op;
  logic [W-1:0]   E_valC;
  logic [W-1:0]   E_valA;
  logic           in_valid;
  logic           stall;
  logic           bubble;
  logic [W-1:0]   e_aluA;
  logic [W-1:0]   aluA_q;
  logic           valid_q;
  logic           illegal_q;

  modport master (
    output E_op, E_valC, E_valA, in_valid, stall, bubble,
    input  e_aluA, aluA_q, valid_q, illegal_q
  );

  modport slave (
    input  E_op, E_valC, E_valA, in_valid, stall, bubble,
    output e_aluA, aluA_q, valid_q, illegal_q
  );
endinterface

// File: rtl/alu_a_sel.sv
// ALU A-operand selector for the Execute stage.
// Selects register operand, immediate or zero by opcode; provides the result
// combinationally (e_aluA) and as a 1-cycle registered copy with stall/bubble
// control and an illegal-opcode flag.
// Ports: clk, rst_n (async active-low), bus (alu_a_sel_if.slave).
module alu_a_sel #(
  parameter int unsigned    W       = 32,
  parameter int unsigned    OPW     = 6,
  parameter logic [OPW-1:0] OP_ROP  = 6'h00,
  parameter logic [OPW-1:0] OP_J    = 6'h02,
  parameter logic [OPW-1:0] OP_ADDI = 6'h08,
  parameter logic [OPW-1:0] OP_ANDI = 6'h0C,
  parameter logic [OPW-1:0] OP_ORI  = 6'h0D,
  parameter logic [OPW-1:0] OP_LW   = 6'h23,
  parameter logic [OPW-1:0] OP_SW   = 6'h2B
) (
  input logic         clk,
  input logic         rst_n,
  alu_a_sel_if.slave  bus
);

  logic [W-1:0] aluASel;
  logic         illegal;

  // Opcode decode; unknown opcodes yield zero and raise illegal.
  always_comb begin
    aluASel = '0;
    illegal = 1'b0;
    case (bus.E_op)
      OP_ROP:                                  aluASel = bus.E_valA;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW:  aluASel = bus.E_valC;
      OP_J:                                    aluASel = '0;
      default:                                 illegal = 1'b1;
    endcase
  end

  assign bus.e_aluA = aluASel;

  // Pipeline register: bubble beats stall; operand is captured even when invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.aluA_q    <= '0;
      bus.valid_q   <= 1'b0;
      bus.illegal_q <= 1'b0;
    end else if (bus.bubble) begin
      bus.aluA_q    <= '0;
      bus.valid_q   <= 1'b0;
      bus.illegal_q <= 1'b0;
    end else if (!bus.stall) begin
      bus.aluA_q    <= aluASel;
      bus.valid_q   <= bus.in_valid;
      bus.illegal_q <= illegal & bus.in_valid;
    end
  end

endmodule

// File: tb/tb_alu_a_sel.sv
// Self-checking bench for alu_a_sel: table-driven vectors plus hand-written
// reset sequences.
module tb_alu_a_sel;

  localparam logic [5:0] ROP  = 6'h00;
  localparam logic [5:0] J    = 6'h02;
  localparam logic [5:0] ADDI = 6'h08;
  localparam logic [5:0] ANDI = 6'h0C;
  localparam logic [5:0] ORI  = 6'h0D;
  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] SW   = 6'h2B;
  localparam logic [5:0] BAD  = 6'h3F;
  localparam int unsigned NVEC = 25;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] valA;
    logic [31:0] valC;
    logic        inValid;
    logic        stall;
    logic        bubble;
    logic [31:0] expComb;
    logic [31:0] expQ;
    logic        expValid;
    logic        expIllegal;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs [NVEC];

  alu_a_sel_if #(.W(32), .OPW(6)) bus ();

  alu_a_sel dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkRegs(input string tag, input logic [31:0] q, input logic v, input logic il);
    check({tag, " aluA_q"}, bus.aluA_q, q);
    check({tag, " valid_q"}, 32'(bus.valid_q), 32'(v));
    check({tag, " illegal_q"}, 32'(bus.illegal_q), 32'(il));
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] c,
                       input logic v, input logic s, input logic b);
    bus.E_op     = op;
    bus.E_valA   = a;
    bus.E_valC   = c;
    bus.in_valid = v;
    bus.stall    = s;
    bus.bubble   = b;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //            op    valA          valC          v     s     b     comb          q             vq    iq
    vecs[0]  = '{ROP,  32'h23,       32'h11,       1'b1, 1'b0, 1'b0, 32'h23,       32'h23,       1'b1, 1'b0};
    vecs[1]  = '{ADDI, 32'h23,       32'h11,       1'b1, 1'b0, 1'b0, 32'h11,       32'h11,       1'b1, 1'b0};
    vecs[2]  = '{ANDI, 32'h23,       32'h11,       1'b1, 1'b0, 1'b0, 32'h11,       32'h11,       1'b1, 1'b0};
    vecs[3]  = '{ORI,  32'h23,       32'h11,       1'b1, 1'b0, 1'b0, 32'h11,       32'h11,       1'b1, 1'b0};
    vecs[4]  = '{SW,   32'h23,       32'h11,       1'b1, 1'b0, 1'b0, 32'h11,       32'h11,       1'b1, 1'b0};
    vecs[5]  = '{LW,   32'h23,       32'h11,       1'b1, 1'b0, 1'b0, 32'h11,       32'h11,       1'b1, 1'b0};
    vecs[6]  = '{J,    32'h23,       32'h11,       1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[7]  = '{BAD,  32'h23,       32'h11,       1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1};
    vecs[8]  = '{ROP,  32'h23,       32'h11,       1'b1, 1'b0, 1'b0, 32'h23,       32'h23,       1'b1, 1'b0};
    vecs[9]  = '{ROP,  32'hDEADBEEF, 32'h11,       1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[10] = '{ADDI, 32'h23,       32'h11,       1'b1, 1'b0, 1'b0, 32'h11,       32'h11,       1'b1, 1'b0};
    vecs[11] = '{ROP,  32'h55,       32'h11,       1'b1, 1'b1, 1'b0, 32'h55,       32'h11,       1'b1, 1'b0};
    vecs[12] = '{ROP,  32'h55,       32'h11,       1'b1, 1'b1, 1'b0, 32'h55,       32'h11,       1'b1, 1'b0};
    vecs[13] = '{ROP,  32'h55,       32'h11,       1'b1, 1'b1, 1'b0, 32'h55,       32'h11,       1'b1, 1'b0};
    vecs[14] = '{ROP,  32'h55,       32'h11,       1'b1, 1'b0, 1'b0, 32'h55,       32'h55,       1'b1, 1'b0};
    vecs[15] = '{BAD,  32'h55,       32'h11,       1'b1, 1'b1, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[16] = '{BAD,  32'h55,       32'h11,       1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[17] = '{ROP,  32'h77,       32'h11,       1'b0, 1'b0, 1'b0, 32'h77,       32'h77,       1'b0, 1'b0};
    vecs[18] = '{BAD,  32'h77,       32'h11,       1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1};
    vecs[19] = '{ROP,  32'h99,       32'h11,       1'b1, 1'b1, 1'b0, 32'h99,       32'h0,        1'b1, 1'b1};
    vecs[20] = '{ROP,  32'h99,       32'h11,       1'b1, 1'b0, 1'b1, 32'h99,       32'h0,        1'b0, 1'b0};
    vecs[21] = '{ROP,  32'hFFFFFFFF, 32'h11,       1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[22] = '{LW,   32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 1'b1, 1'b0};
    vecs[23] = '{J,    32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[24] = '{6'h01,32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1};

    // Reset held across edges
    rst_n = 1'b0;
    drive(ROP, 32'h1234, 32'h5678, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 checkRegs("reset", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].valA, vecs[i].valC, vecs[i].inValid, vecs[i].stall, vecs[i].bubble);
      #1 check($sformatf("vec%0d e_aluA", i), bus.e_aluA, vecs[i].expComb);
      @(posedge clk);
      #1 checkRegs($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expValid, vecs[i].expIllegal);
    end

    // Mid-cycle asynchronous reset clears registered outputs immediately
    @(negedge clk);
    drive(ROP, 32'hDEADBEEF, 32'h11, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 checkRegs("pre-async", 32'hDEADBEEF, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkRegs("async-rst", 32'h0, 1'b0, 1'b0);
    check("async-rst e_aluA", bus.e_aluA, 32'hDEADBEEF);
    @(posedge clk);
    #1 checkRegs("rst-held", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 checkRegs("post-rst", 32'hDEADBEEF, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_a_sel.md
Name: alu_a_sel

Overview:
- ALU A-operand selector for the Execute stage of the pipelined MIPS CPU.
- Picks the ALU A input from the register operand (E_valA), the immediate (E_valC) or zero, based on the instruction opcode E_op.
- Provides a same-cycle combinational result and a registered copy (1-cycle latency) with stall/bubble control and an illegal-opcode flag.

Parameters:
- W, 32, datapath width of E_valA, E_valC and e_aluA.
- OPW, 6, opcode width.
- OP_ROP, 6'h00, R-type opcode.
- OP_J, 6'h02, jump opcode.
- OP_ADDI, 6'h08, add-immediate opcode.
- OP_ANDI, 6'h0C, and-immediate opcode.
- OP_ORI, 6'h0D, or-immediate opcode.
- OP_LW, 6'h23, load-word opcode.
- OP_SW, 6'h2B, store-word opcode.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- E_op  in  OPW  opcode of the instruction in Execute.
- E_valC  in  W  immediate, already extended by Decode.
- E_valA  in  W  register operand A, already forwarded.
- in_valid  in  1  Execute-stage instruction is valid.
- stall  in  1  hold the registered outputs.
- bubble  in  1  load a NOP into the registered outputs.
- e_aluA  out  W  combinational ALU A operand.
- aluA_q  out  W  registered ALU A operand.
- valid_q  out  1  registered valid.
- illegal_q  out  1  registered illegal-opcode flag.

Behaviour:
Combinational selection (e_aluA), purely a function of E_op, E_valA and E_valC, with no dependence on clk/rst_n:
- OP_ROP -> E_valA.
- OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW -> E_valC, passed through unchanged (no re-extension).
- OP_J -> 0.
- Any other opcode -> 0, and the internal illegal signal is 1.
- illegal is 0 for the seven listed opcodes.
- e_aluA must settle in the same delta/cycle that the inputs change.

Registered path:
- Asynchronous reset while rst_n=0: aluA_q=0, valid_q=0, illegal_q=0. Outputs clear immediately on rst_n falling, including mid-operation; the first capture is on the first rising clk edge after rst_n rises.
- On each rising edge with rst_n=1, apply the first matching rule, in priority order:
  1. bubble=1 -> aluA_q=0, valid_q=0, illegal_q=0. Bubble wins over stall.
  2. stall=1 -> all registered outputs hold their values.
  3. Otherwise -> aluA_q=e_aluA, valid_q=in_valid, illegal_q=illegal & in_valid.
- Latency: registered outputs reflect inputs exactly one clock after capture.
- in_valid=0 still captures e_aluA into aluA_q; only valid_q and illegal_q are forced low.
- No wrap-around or arithmetic; values pass through bit-exact. Full 32-bit values (e.g. 0xFFFFFFFF) must pass through unmodified.

Test Plan:
1. E_valA=0x23, E_valC=0x11. Step E_op through ROP, ADDI, ANDI, ORI, SW, LW, J at 10 ns intervals -> e_aluA = 0x23, 0x11, 0x11, 0x11, 0x11, 0x11, 0x00.
2. E_op=0x3F, in_valid=1, clock once -> e_aluA=0, aluA_q=0, valid_q=1, illegal_q=1. Then E_op=ROP -> illegal_q=0 on the next edge.
3. Reset and 1-cycle latency:
   - Hold rst_n=0 across edges -> all registered outputs 0.
   - Release, then ROP with E_valA=0xDEADBEEF -> aluA_q=0xDEADBEEF one edge after capture.
   - Drop rst_n mid-cycle -> aluA_q=0 immediately.
4. Capture ADDI with E_valC=0x11, then assert stall=1 and change inputs to ROP, E_valA=0x55 for 3 cycles -> aluA_q stays 0x11. Release stall -> 0x55 on the next edge.
5. Assert stall=1 and bubble=1 together -> aluA_q=0, valid_q=0, illegal_q=0 (bubble priority).
6. E_valA=0xFFFFFFFF with ROP, then E_valC=0x80000000 with LW -> e_aluA and aluA_q pass both values bit-exact. J with E_valA=0xFFFFFFFF -> e_aluA=0.
